// File: rtl/direct_mapped_cache_dp.sv
// rtl/direct_mapped_cache_dp.sv - read-only direct-mapped cache (1024 x 4-word lines) over a 32K-word ROM
// Three-state controller: CHECK looks up, FILL loads a block, RESOLVE returns the filled word.
module direct_mapped_cache_dp (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] adr,
  output logic        done,
  output logic [12:0] hit_cnt,
  output logic [31:0] o_data
);

  typedef enum logic [1:0] {CHECK, FILL, RESOLVE} state_t;

  state_t         r_state;
  logic [1023:0]  r_valid;
  logic [2:0]     r_tag  [1024];
  logic [127:0]   r_line [1024];
  logic [12:0]    r_hit_cnt;

  logic [1:0]     w_offset;
  logic [9:0]     w_index;
  logic [2:0]     w_tag;
  logic           w_hit;
  logic           w_read;
  logic           w_write;
  logic           w_mem_ready;
  logic [127:0]   w_mem_block;
  logic [127:0]   w_line;

  assign w_offset = adr[1:0];
  assign w_index  = adr[11:2];
  assign w_tag    = adr[14:12];

  // Main memory holds word i = i, so the aligned block is derived from the address itself.
  always_comb begin
    w_mem_block = '0;
    for (int k = 0; k < 4; k++) begin
      w_mem_block[32*k +: 32] = {17'd0, adr[14:2], 2'(k)};
    end
  end

  assign w_mem_ready = w_read;
  assign w_read      = (r_state == FILL);
  assign w_write     = w_read && w_mem_ready;

  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line  = r_line[w_index];
  assign o_data  = w_line[{w_offset, 5'b0} +: 32];
  assign hit_cnt = r_hit_cnt;

  always_comb begin
    done = 1'b0;
    if (r_state == RESOLVE)
      done = 1'b1;
    else if (r_state == CHECK && w_hit)
      done = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CHECK;
      r_valid   <= '0;
      r_hit_cnt <= '0;
    end else begin
      case (r_state)
        CHECK: begin
          if (w_hit)
            r_hit_cnt <= r_hit_cnt + 13'd1;
          else
            r_state <= FILL;
        end
        FILL: begin
          if (w_mem_ready) begin
            r_valid[w_index] <= 1'b1;
            r_state          <= RESOLVE;
          end
        end
        RESOLVE: r_state <= CHECK;
        default: r_state <= CHECK;
      endcase
    end
  end

  // Line data and tags carry no reset; validity alone decides whether they are trusted.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_line[w_index] <= w_mem_block;
      r_tag[w_index]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache_dp.sv
// tb/tb_direct_mapped_cache_dp.sv - directed bench for direct_mapped_cache_dp
module tb_direct_mapped_cache_dp;

  logic        clk;
  logic        rst;
  logic [14:0] adr;
  logic        done;
  logic [12:0] hit_cnt;
  logic [31:0] o_data;

  int checks;
  int errors;

  typedef struct {
    logic [14:0] adr;
    int          lat;
    logic [31:0] data;
    logic [12:0] hits;
  } vec_t;

  vec_t vecs [8];

  direct_mapped_cache_dp dut (
    .clk     (clk),
    .rst     (rst),
    .adr     (adr),
    .done    (done),
    .hit_cnt (hit_cnt),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge following done.
  task automatic access(input logic [14:0] a, output int lat, output logic [31:0] d);
    adr = a;
    lat = 0;
    d   = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        d   = o_data;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hit_cnt", 32'(hit_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] d;
    int          bad;
    int          exp_lat;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    adr    = 15'd0;

    vecs[0] = '{adr: 15'd1001, lat: 1, data: 32'd1001, hits: 13'd1};
    vecs[1] = '{adr: 15'd1002, lat: 1, data: 32'd1002, hits: 13'd2};
    vecs[2] = '{adr: 15'd1003, lat: 1, data: 32'd1003, hits: 13'd3};
    vecs[3] = '{adr: 15'd5096, lat: 3, data: 32'd5096, hits: 13'd3};
    vecs[4] = '{adr: 15'd1000, lat: 3, data: 32'd1000, hits: 13'd3};
    vecs[5] = '{adr: 15'd1001, lat: 1, data: 32'd1001, hits: 13'd4};
    vecs[6] = '{adr: 15'd5097, lat: 3, data: 32'd5097, hits: 13'd4};
    vecs[7] = '{adr: 15'd5097, lat: 1, data: 32'd5097, hits: 13'd5};

    do_reset();

    // First miss walked cycle by cycle.
    adr = 15'd1000;
    @(negedge clk);
    chk("miss_c1_done", 32'(done), 32'd0);
    chk("miss_c1_read", 32'(dut.w_read), 32'd0);
    @(negedge clk);
    chk("miss_c2_rw", 32'({dut.w_read, dut.w_write}), 32'd3);
    chk("miss_c2_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("miss_c3_done", 32'(done), 32'd1);
    chk("miss_c3_data", o_data, 32'd1000);
    @(posedge clk); #1;
    chk("miss_hit_cnt", 32'(hit_cnt), 32'd0);

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].adr, lat, d);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_data", i), d, vecs[i].data);
      chk($sformatf("vec%0d_hits", i), 32'(hit_cnt), 32'(vecs[i].hits));
    end

    // Reset in the middle of a fill must leave the line invalid.
    do_reset();
    adr = 15'd2000;
    @(negedge clk);
    chk("abort_c1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_in_fill", 32'(dut.w_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(15'd2000, lat, d);
    chk("abort_lat", 32'(lat), 32'd3);
    chk("abort_data", d, 32'd2000);
    chk("abort_hits", 32'(hit_cnt), 32'd0);

    // Streaming 4000 consecutive words.
    do_reset();
    bad = 0;
    for (int a = 1000; a < 5000; a++) begin
      exp_lat = (a % 4 == 0) ? 3 : 1;
      access(15'(a), lat, d);
      if (lat != exp_lat || d != 32'(a)) bad++;
    end
    chk("stream_errors", 32'(bad), 32'd0);
    chk("stream_hits", 32'(hit_cnt), 32'd3000);

    // hit_cnt wrap by holding one cached address.
    do_reset();
    access(15'd0, lat, d);
    chk("wrap_fill_lat", 32'(lat), 32'd3);
    repeat (8191) @(posedge clk);
    #1;
    chk("wrap_8191", 32'(hit_cnt), 32'd8191);
    chk("wrap_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("wrap_zero", 32'(hit_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
